// File: rtl/imem_arbiter.sv
// Two-port arbiter sharing the combinational boot ROM between fetch and load.
// Fetch wins by default; a starvation counter forces a waiting load through.
module imem_arbiter #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
   parameter int unsigned              ROM_BYTES     = 4096,
   parameter int unsigned              STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req,
   input  logic [ADDRESS_WIDTH-1:0] if_addr,
   output logic                     if_gnt,
   output logic                     if_rvalid,
   output logic [DATA_WIDTH-1:0]    if_rdata,
   output logic                     if_err,
   input  logic                     ld_req,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr,
   output logic                     ld_gnt,
   output logic                     ld_rvalid,
   output logic [DATA_WIDTH-1:0]    ld_rdata,
   output logic                     ld_err,
   input  logic                     flush,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]    mem_rd
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
      BASE_ADDR + ADDRESS_WIDTH'(ROM_BYTES) - ADDRESS_WIDTH'(4);

   typedef enum logic [1:0] {
      S_NONE,
      S_IF,
      S_LD
   } sel_t;

   sel_t                     r_sel;
   logic [CW-1:0]            r_cnt;
   logic [DATA_WIDTH-1:0]    r_data;
   logic                     r_err;
   logic [DATA_WIDTH-1:0]    r_if_rdata;
   logic                     r_if_err;
   logic [DATA_WIDTH-1:0]    r_ld_rdata;
   logic                     r_ld_err;

   logic                     w_ld_force;
   logic                     w_any;
   logic                     w_valid;
   logic [ADDRESS_WIDTH-1:0] w_gaddr;

   assign w_ld_force = (r_cnt == CNT_MAX);
   assign if_gnt = rst & if_req & ~flush & ~(w_ld_force & ld_req);
   assign ld_gnt = rst & ld_req & ~if_gnt;
   assign w_any = if_gnt | ld_gnt;
   assign w_gaddr = if_gnt ? if_addr : ld_addr;

   assign w_valid = (w_gaddr >= BASE_ADDR) &&
                    (w_gaddr <= LAST_ADDR) &&
                    (w_gaddr[1:0] == 2'b00);

   assign mem_addr = (w_any && w_valid) ? w_gaddr : BASE_ADDR;

   // A redirect kills the fetch response presented in the same cycle.
   assign if_rvalid = (r_sel == S_IF) & ~flush;
   assign ld_rvalid = (r_sel == S_LD);

   // Per-port shadows keep rdata/err stable between responses.
   assign if_rdata = if_rvalid ? r_data : r_if_rdata;
   assign if_err   = if_rvalid ? r_err  : r_if_err;
   assign ld_rdata = ld_rvalid ? r_data : r_ld_rdata;
   assign ld_err   = ld_rvalid ? r_err  : r_ld_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sel      <= S_NONE;
         r_cnt      <= '0;
         r_data     <= '0;
         r_err      <= 1'b0;
         r_if_rdata <= '0;
         r_if_err   <= 1'b0;
         r_ld_rdata <= '0;
         r_ld_err   <= 1'b0;
      end else begin
         if (if_rvalid) begin
            r_if_rdata <= r_data;
            r_if_err   <= r_err;
         end
         if (ld_rvalid) begin
            r_ld_rdata <= r_data;
            r_ld_err   <= r_err;
         end
         unique case (1'b1)
            if_gnt:  r_sel <= S_IF;
            ld_gnt:  r_sel <= S_LD;
            default: r_sel <= S_NONE;
         endcase
         if (w_any) begin
            r_data <= w_valid ? mem_rd : '0;
            r_err  <= ~w_valid;
         end
         if (ld_req && !ld_gnt) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic        ld_gnt;
   logic        ld_rvalid;
   logic [31:0] ld_rdata;
   logic        ld_err;
   logic        flush;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd;

   logic [7:0] rom [4096];

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int          m_cnt;
   int          m_port;
   logic [31:0] m_d;
   logic        m_e;
   logic [31:0] m_if_d;
   logic        m_if_e;
   logic [31:0] m_ld_d;
   logic        m_ld_e;
   logic        e_ifg;
   logic        e_ldg;

   // snapshots of DUT outputs for the most recent cycle
   logic        s_ifg, s_ldg, s_ifv, s_ife, s_ldv, s_lde;
   logic [31:0] s_ifd, s_ldd, s_maddr;

   logic p_if, p_ld;

   imem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_gnt    (ld_gnt),
      .ld_rvalid (ld_rvalid),
      .ld_rdata  (ld_rdata),
      .ld_err    (ld_err),
      .flush     (flush),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [11:0] o;
      o = a[11:0];
      return {rom[o], rom[o + 12'd1], rom[o + 12'd2], rom[o + 12'd3]};
   endfunction

   assign mem_rd = rom_word(mem_addr);

   function automatic bit addr_ok(input logic [31:0] a);
      longint unsigned v;
      v = longint'(a);
      return (v >= longint'(BASE)) && (v <= longint'(BASE) + 4092) &&
             (v % 4 == 0);
   endfunction

   always @(posedge clk) begin
      p_if <= rst & if_req & ~if_gnt;
      p_ld <= rst & ld_req & ~ld_gnt;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_port = 0;
      m_d    = '0;
      m_e    = 1'b0;
      m_if_d = '0;
      m_if_e = 1'b0;
      m_ld_d = '0;
      m_ld_e = 1'b0;
   endtask

   task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la,
                      input logic fl);
      logic        e_ifv, e_ldv;
      logic [31:0] ga, e_ma;
      @(negedge clk);
      rst = r; if_req = ir; if_addr = ia;
      ld_req = lr; ld_addr = la; flush = fl;
      #1;
      if (r && p_if)
         assert (if_req) else $error("protocol: if_req withdrawn");
      if (r && p_ld)
         assert (ld_req) else $error("protocol: ld_req withdrawn");
      e_ifg = r && ir && !fl && !(m_cnt == 4 && lr);
      e_ldg = r && lr && !e_ifg;
      ga = e_ifg ? ia : la;
      e_ma = ((e_ifg || e_ldg) && addr_ok(ga)) ? ga : BASE;
      e_ifv = (m_port == 1) && !fl;
      e_ldv = (m_port == 2);
      s_ifg = if_gnt; s_ldg = ld_gnt; s_maddr = mem_addr;
      s_ifv = if_rvalid; s_ifd = if_rdata; s_ife = if_err;
      s_ldv = ld_rvalid; s_ldd = ld_rdata; s_lde = ld_err;
      chk("if_gnt", s_ifg, e_ifg);
      chk("ld_gnt", s_ldg, e_ldg);
      chk("mem_addr", s_maddr, e_ma);
      chk("if_rvalid", s_ifv, e_ifv);
      chk("ld_rvalid", s_ldv, e_ldv);
      chk("if_rdata", s_ifd, e_ifv ? m_d : m_if_d);
      chk("if_err", s_ife, e_ifv ? m_e : m_if_e);
      chk("ld_rdata", s_ldd, e_ldv ? m_d : m_ld_d);
      chk("ld_err", s_lde, e_ldv ? m_e : m_ld_e);
      if (!r) begin
         model_reset();
      end else begin
         if (e_ifv) begin m_if_d = m_d; m_if_e = m_e; end
         if (e_ldv) begin m_ld_d = m_d; m_ld_e = m_e; end
         m_port = e_ifg ? 1 : (e_ldg ? 2 : 0);
         if (e_ifg || e_ldg) begin
            m_d = addr_ok(ga) ? rom_word(ga) : 32'h0;
            m_e = !addr_ok(ga);
         end
         if (lr && !e_ldg) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
         else m_cnt = 0;
      end
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, BASE, 1'b0, BASE, 1'b0);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom % 8)
         0:       return BASE - 32'(4 * ($urandom_range(1, 4)));
         1:       return BASE + 32'd4096 + 32'($urandom % 8);
         2:       return BASE + 32'($urandom % 4096);
         default: return BASE + 32'(4 * ($urandom % 1024));
      endcase
   endfunction

   initial begin
      logic        ir, lr, fl, r;
      logic [31:0] ia, la;
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h93;

      rst = 1'b0; if_req = 1'b0; ld_req = 1'b0; flush = 1'b0;
      if_addr = BASE; ld_addr = BASE;
      repeat (2) @(posedge clk);
      model_reset();

      // reset state
      cyc(1'b0, 1'b0, BASE, 1'b0, BASE, 1'b0);
      chk("rst_if_rvalid", s_ifv, 1'b0);
      chk("rst_ld_rdata", s_ldd, 32'h0);

      // IF alone at ROM base
      cyc(1'b1, 1'b1, BASE, 1'b0, BASE, 1'b0);
      chk("if0_gnt", s_ifg, 1'b1);
      idle();
      chk("if0_rvalid", s_ifv, 1'b1);
      chk("if0_rdata", s_ifd, 32'h13000093);
      chk("if0_err", s_ife, 1'b0);

      // continuous IF with a waiting load
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1, BASE + 32'(4 * i), i < 5, BASE + 32'h10, 1'b0);
         chk("starve_ld_gnt", s_ldg, i == 4);
         chk("starve_if_gnt", s_ifg, i != 4);
         if (i == 5) begin
            chk("starve_ld_rvalid", s_ldv, 1'b1);
            chk("starve_ld_rdata", s_ldd, rom_word(BASE + 32'h10));
         end
      end
      idle();

      // range and alignment errors
      cyc(1'b1, 1'b0, BASE, 1'b1, BASE + 32'h1000, 1'b0);
      chk("oor_mem_addr", s_maddr, BASE);
      idle();
      chk("oor_ld_err", s_lde, 1'b1);
      chk("oor_ld_rdata", s_ldd, 32'h0);
      cyc(1'b1, 1'b1, BASE + 32'h2, 1'b0, BASE, 1'b0);
      idle();
      chk("mis_if_err", s_ife, 1'b1);
      cyc(1'b1, 1'b1, BASE + 32'hFFC, 1'b0, BASE, 1'b0);
      idle();
      chk("top_if_err", s_ife, 1'b0);
      chk("top_if_rdata", s_ifd, rom_word(BASE + 32'hFFC));

      // flush kills fetch response, load proceeds
      cyc(1'b1, 1'b1, BASE + 32'h40, 1'b0, BASE, 1'b0);
      cyc(1'b1, 1'b1, BASE + 32'h44, 1'b1, BASE + 32'h20, 1'b1);
      chk("fl_if_rvalid", s_ifv, 1'b0);
      chk("fl_if_gnt", s_ifg, 1'b0);
      chk("fl_ld_gnt", s_ldg, 1'b1);
      cyc(1'b1, 1'b1, BASE + 32'h44, 1'b0, BASE, 1'b0);
      chk("fl_ld_rvalid", s_ldv, 1'b1);
      chk("fl_ld_rdata", s_ldd, rom_word(BASE + 32'h20));
      idle();

      // back-to-back alternation
      cyc(1'b1, 1'b1, BASE + 32'h08, 1'b0, BASE, 1'b0);
      cyc(1'b1, 1'b0, BASE, 1'b1, BASE + 32'h0C, 1'b0);
      chk("alt_if_rdata", s_ifd, rom_word(BASE + 32'h08));
      chk("alt_ld_rvalid1", s_ldv, 1'b0);
      cyc(1'b1, 1'b1, BASE + 32'h14, 1'b0, BASE, 1'b0);
      chk("alt_ld_rdata", s_ldd, rom_word(BASE + 32'h0C));
      chk("alt_if_rvalid2", s_ifv, 1'b0);
      idle();
      chk("alt_if_rdata2", s_ifd, rom_word(BASE + 32'h14));

      // reset in the middle of a granted fetch
      cyc(1'b1, 1'b1, BASE + 32'h30, 1'b1, BASE + 32'h34, 1'b0);
      chk("mid_if_gnt", s_ifg, 1'b1);
      rst = 1'b0;
      model_reset();
      idle();
      chk("mid_if_rvalid", s_ifv, 1'b0);
      chk("mid_if_rdata", s_ifd, 32'h0);
      cyc(1'b1, 1'b1, BASE + 32'h04, 1'b0, BASE, 1'b0);
      idle();
      chk("mid_resume", s_ifd, rom_word(BASE + 32'h04));

      // randomized traffic
      ir = 1'b0; lr = 1'b0; ia = BASE; la = BASE;
      r = 1'b1; e_ifg = 1'b0; e_ldg = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!r || !ir || e_ifg) begin
            ir = ($urandom % 4) != 0;
            ia = rand_addr();
         end
         if (!r || !lr || e_ldg) begin
            lr = ($urandom % 2) != 0;
            la = rand_addr();
         end
         fl = ($urandom % 8) == 0;
         r  = ($urandom % 64) != 0;
         cyc(r, ir, ia, lr, la, fl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
